// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if
//   Bundles every signal between the two ALU clients, the shared-ALU arbiter
//   and the ALU instance itself.
//   Ports (seen from the arbiter, modport slave):
//     req0/1_valid_i, req0/1_ctrl_i, req0/1_src1_i, req0/1_src2_i  in   requests
//     req0/1_ready_o                                               out  request accepted
//     rsp0/1_valid_o, rsp_result_o, rsp_zero_o                     out  responses
//     rsp0/1_ready_i                                               in   response consumed
//     alu_src1_o, alu_src2_o, alu_ctrl_o                           out  to ALU
//     alu_result_i, alu_zero_i                                     in   from ALU
//   modport master is the environment side: the clients plus the ALU.
interface alu_share_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
);
   logic              req0_valid_i;
   logic              req1_valid_i;
   logic              req0_ready_o;
   logic              req1_ready_o;
   logic [CTRL_W-1:0] req0_ctrl_i;
   logic [CTRL_W-1:0] req1_ctrl_i;
   logic [DATA_W-1:0] req0_src1_i;
   logic [DATA_W-1:0] req0_src2_i;
   logic [DATA_W-1:0] req1_src1_i;
   logic [DATA_W-1:0] req1_src2_i;
   logic              rsp0_valid_o;
   logic              rsp1_valid_o;
   logic              rsp0_ready_i;
   logic              rsp1_ready_i;
   logic [DATA_W-1:0] rsp_result_o;
   logic              rsp_zero_o;
   logic [DATA_W-1:0] alu_src1_o;
   logic [DATA_W-1:0] alu_src2_o;
   logic [CTRL_W-1:0] alu_ctrl_o;
   logic [DATA_W-1:0] alu_result_i;
   logic              alu_zero_i;

   modport slave (
      input  req0_valid_i, req1_valid_i, req0_ctrl_i, req1_ctrl_i,
      input  req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i,
      output req0_ready_o, req1_ready_o,
      output rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_zero_o,
      input  rsp0_ready_i, rsp1_ready_i,
      output alu_src1_o, alu_src2_o, alu_ctrl_o,
      input  alu_result_i, alu_zero_i
   );

   modport master (
      output req0_valid_i, req1_valid_i, req0_ctrl_i, req1_ctrl_i,
      output req0_src1_i, req0_src2_i, req1_src1_i, req1_src2_i,
      input  req0_ready_o, req1_ready_o,
      input  rsp0_valid_o, rsp1_valid_o, rsp_result_o, rsp_zero_o,
      output rsp0_ready_i, rsp1_ready_i,
      input  alu_src1_o, alu_src2_o, alu_ctrl_o,
      output alu_result_i, alu_zero_i
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Round-robin arbiter/sequencer sharing one combinational ALU between two
//   requesters. One operation is in flight at a time: accept (IDLE), drive
//   the ALU from registered operands (EXEC), return the registered result to
//   the owner until it is consumed (RESP).
//   Ports:
//     clk_i  in  clock, rising edge
//     rst_i  in  asynchronous active-high reset
//     bus    alu_share_arbiter_if.slave -- request/response handshakes for
//            both clients plus the ALU operand/result connection
module alu_share_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   alu_share_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              owner;
   logic              last_grant;
   logic [CTRL_W-1:0] op_ctrl;
   logic [DATA_W-1:0] op_src1;
   logic [DATA_W-1:0] op_src2;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic              grant0;
   logic              grant1;
   logic              accept;
   logic              rsp_taken;

   always_comb begin
      grant0    = 1'b0;
      grant1    = 1'b0;
      state_nxt = state;
      rsp_taken = owner ? bus.rsp1_ready_i : bus.rsp0_ready_i;
      case (state)
         IDLE: begin
            // On a tie the requester that did not win last time goes first.
            if (bus.req0_valid_i && bus.req1_valid_i) begin
               grant0 = last_grant;
               grant1 = ~last_grant;
            end else begin
               grant0 = bus.req0_valid_i;
               grant1 = bus.req1_valid_i;
            end
            if (grant0 || grant1) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: if (rsp_taken) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = grant0 | grant1;

   // Ready is combinational from state, so it is masked while reset is held.
   assign bus.req0_ready_o = grant0 & ~rst_i;
   assign bus.req1_ready_o = grant1 & ~rst_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         op_ctrl    <= '0;
         op_src1    <= '0;
         op_src2    <= '0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
      end else begin
         state <= state_nxt;
         // accept stage: latch the winner's operation
         if (accept) begin
            owner      <= grant1;
            last_grant <= grant1;
            op_ctrl    <= grant1 ? bus.req1_ctrl_i : bus.req0_ctrl_i;
            op_src1    <= grant1 ? bus.req1_src1_i : bus.req0_src1_i;
            op_src2    <= grant1 ? bus.req1_src2_i : bus.req0_src2_i;
         end
         // execute stage: the ALU output is only trusted in this cycle
         if (state == EXEC) begin
            rsp_result <= bus.alu_result_i;
            rsp_zero   <= bus.alu_zero_i;
         end
      end
   end

   // response stage: outputs come straight from registers
   assign bus.rsp0_valid_o = (state == RESP) & ~owner;
   assign bus.rsp1_valid_o = (state == RESP) &  owner;
   assign bus.rsp_result_o = rsp_result;
   assign bus.rsp_zero_o   = rsp_zero;

   assign bus.alu_ctrl_o = op_ctrl;
   assign bus.alu_src1_o = op_src1;
   assign bus.alu_src2_o = op_src2;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
   localparam int DATA_W = 32;
   localparam int CTRL_W = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   alu_share_arbiter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

   alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU behaviour: 0 AND, 1 OR, 2 ADD, 4 MUL, 6 SUB, 7 SLT (unsigned).
   function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] p;
      case (c)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd4: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
         4'd6: return a - b;
         4'd7: return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // The ALU instance the arbiter drives.
   assign bus.alu_result_i = ref_alu(bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o);
   assign bus.alu_zero_i   = (bus.alu_result_i == 32'd0);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   // Transaction view: an operation is pending from its accept until consumed;
   // its response is due from the second cycle after the accept.
   bit          m_pend;
   int          m_acc_cyc;
   int          m_cyc;
   int          m_who;
   int          m_tie;     // requester that wins the next tie
   logic [31:0] m_ctrl, m_a, m_b, m_res;

   initial begin
      m_pend = 0; m_acc_cyc = 0; m_cyc = 0; m_who = 0; m_tie = 0;
      m_ctrl = 0; m_a = 0; m_b = 0; m_res = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_ready0", bus.req0_ready_o, 0);
            chk("rst_ready1", bus.req1_ready_o, 0);
            chk("rst_rsp0_valid", bus.rsp0_valid_o, 0);
            chk("rst_rsp1_valid", bus.rsp1_valid_o, 0);
            chk("rst_alu_ctrl", bus.alu_ctrl_o, 0);
            chk("rst_alu_src1", bus.alu_src1_o, 0);
            chk("rst_alu_src2", bus.alu_src2_o, 0);
            chk("rst_result", bus.rsp_result_o, 0);
            chk("rst_zero", bus.rsp_zero_o, 0);
            m_pend = 0; m_tie = 0; m_ctrl = 0; m_a = 0; m_b = 0; m_res = 0;
         end else begin
            bit v0, v1, e_r0, e_r1, due;
            m_cyc++;
            v0   = bus.req0_valid_i;
            v1   = bus.req1_valid_i;
            e_r0 = !m_pend && v0 && (!v1 || m_tie == 0);
            e_r1 = !m_pend && v1 && (!v0 || m_tie == 1);
            due  = m_pend && (m_cyc - m_acc_cyc >= 2);
            chk("m_ready0", bus.req0_ready_o, e_r0);
            chk("m_ready1", bus.req1_ready_o, e_r1);
            chk("m_rsp0_valid", bus.rsp0_valid_o, due && m_who == 0);
            chk("m_rsp1_valid", bus.rsp1_valid_o, due && m_who == 1);
            chk("m_alu_ctrl", bus.alu_ctrl_o, m_ctrl);
            chk("m_alu_src1", bus.alu_src1_o, m_a);
            chk("m_alu_src2", bus.alu_src2_o, m_b);
            if (due) begin
               chk("m_result", bus.rsp_result_o, m_res);
               chk("m_zero", bus.rsp_zero_o, m_res == 32'd0);
            end
            if (e_r0 || e_r1) begin
               m_pend    = 1;
               m_acc_cyc = m_cyc;
               m_who     = e_r1 ? 1 : 0;
               m_tie     = 1 - m_who;
               m_ctrl    = e_r1 ? 32'(bus.req1_ctrl_i) : 32'(bus.req0_ctrl_i);
               m_a       = e_r1 ? bus.req1_src1_i : bus.req0_src1_i;
               m_b       = e_r1 ? bus.req1_src2_i : bus.req0_src2_i;
               m_res     = ref_alu(m_ctrl[3:0], m_a, m_b);
            end else if (due && ((m_who == 0) ? bus.rsp0_ready_i : bus.rsp1_ready_i)) begin
               m_pend = 0;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic send(input int who, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
      bit ok;
      if (who == 0) begin
         bus.req0_ctrl_i = c; bus.req0_src1_i = a; bus.req0_src2_i = b; bus.req0_valid_i = 1;
      end else begin
         bus.req1_ctrl_i = c; bus.req1_src1_i = a; bus.req1_src2_i = b; bus.req1_valid_i = 1;
      end
      ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         ok = (who == 0) ? bus.req0_ready_o : bus.req1_ready_o;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_accept: requester %0d got no ready within 40 cycles", who);
      end
      @(posedge clk); #1;
      if (who == 0) bus.req0_valid_i = 0; else bus.req1_valid_i = 0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int who;
      checks = 0; errors = 0;
      rst = 1;
      bus.req0_valid_i = 0; bus.req1_valid_i = 0;
      bus.req0_ctrl_i = 0; bus.req1_ctrl_i = 0;
      bus.req0_src1_i = 0; bus.req0_src2_i = 0;
      bus.req1_src1_i = 0; bus.req1_src2_i = 0;
      bus.rsp0_ready_i = 1; bus.rsp1_ready_i = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Test 1: req0 ADD 5+7 alone
      bus.req0_ctrl_i = 4'd2; bus.req0_src1_i = 5; bus.req0_src2_i = 7; bus.req0_valid_i = 1;
      @(negedge clk);
      chk("t1_ready0", bus.req0_ready_o, 1);
      chk("t1_ready1", bus.req1_ready_o, 0);
      @(posedge clk); #1 bus.req0_valid_i = 0;
      @(negedge clk);
      chk("t1_exec_rsp0_valid", bus.rsp0_valid_o, 0);
      chk("t1_exec_alu_ctrl", bus.alu_ctrl_o, 2);
      @(negedge clk);
      chk("t1_rsp0_valid", bus.rsp0_valid_o, 1);
      chk("t1_rsp1_valid", bus.rsp1_valid_o, 0);
      chk("t1_result", bus.rsp_result_o, 12);
      chk("t1_zero", bus.rsp_zero_o, 0);
      @(negedge clk);
      chk("t1_rsp0_done", bus.rsp0_valid_o, 0);

      // Test 2: both valid continuously; grants alternate starting with req0
      do_reset();
      bus.req0_ctrl_i = 4'd6; bus.req0_src1_i = 9; bus.req0_src2_i = 9;
      bus.req1_ctrl_i = 4'd4; bus.req1_src1_i = 3; bus.req1_src2_i = 4;
      bus.req0_valid_i = 1; bus.req1_valid_i = 1;
      for (int k = 0; k < 12; k++) begin
         found = 0;
         for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = bus.req0_ready_o | bus.req1_ready_o;
         end
         who = bus.req1_ready_o ? 1 : 0;
         chk("t2_grant_found", found, 1);
         chk("t2_grant_order", who, k % 2);
         @(negedge clk);
         @(negedge clk);
         if (k % 2 == 0) begin
            chk("t2_rsp0_valid", bus.rsp0_valid_o, 1);
            chk("t2_sub_result", bus.rsp_result_o, 0);
            chk("t2_sub_zero", bus.rsp_zero_o, 1);
         end else begin
            chk("t2_rsp1_valid", bus.rsp1_valid_o, 1);
            chk("t2_mul_result", bus.rsp_result_o, 12);
            chk("t2_mul_zero", bus.rsp_zero_o, 0);
         end
      end
      @(posedge clk); #1 bus.req0_valid_i = 0; bus.req1_valid_i = 0;

      // Test 3: req1 SLT 2<3 with response back-pressure; req0 waits
      bus.rsp1_ready_i = 0;
      send(1, 4'd7, 2, 3);
      bus.req0_ctrl_i = 4'd0; bus.req0_src1_i = 6; bus.req0_src2_i = 3; bus.req0_valid_i = 1;
      @(negedge clk);
      chk("t3_exec_ready0", bus.req0_ready_o, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t3_hold_valid", bus.rsp1_valid_o, 1);
         chk("t3_hold_result", bus.rsp_result_o, 1);
         chk("t3_hold_ready0", bus.req0_ready_o, 0);
      end
      @(posedge clk); #1 bus.rsp1_ready_i = 1;
      @(negedge clk);
      chk("t3_last_valid", bus.rsp1_valid_o, 1);
      @(negedge clk);
      chk("t3_idle_ready0", bus.req0_ready_o, 1);
      @(posedge clk); #1 bus.req0_valid_i = 0;
      @(negedge clk);
      @(negedge clk);
      chk("t3_and_valid", bus.rsp0_valid_o, 1);
      chk("t3_and_result", bus.rsp_result_o, 2);
      @(posedge clk); #1;

      // Test 4: undefined ctrl 5 returns 0 with zero=1 at normal latency
      send(0, 4'd5, 32'hFFFF_FFFF, 1);
      @(negedge clk);
      chk("t4_exec_valid", bus.rsp0_valid_o, 0);
      @(negedge clk);
      chk("t4_valid", bus.rsp0_valid_o, 1);
      chk("t4_result", bus.rsp_result_o, 0);
      chk("t4_zero", bus.rsp_zero_o, 1);
      @(posedge clk); #1;

      // Test 5a: reset mid-EXEC, with a request pending during reset
      send(0, 4'd2, 1, 1);
      #2 rst = 1; bus.req0_valid_i = 1;
      #1;
      chk("t5a_ready0", bus.req0_ready_o, 0);
      chk("t5a_ready1", bus.req1_ready_o, 0);
      chk("t5a_rsp0_valid", bus.rsp0_valid_o, 0);
      chk("t5a_alu_ctrl", bus.alu_ctrl_o, 0);
      @(posedge clk); #1 rst = 0; bus.req0_valid_i = 0;
      repeat (3) begin
         @(negedge clk);
         chk("t5a_no_rsp", bus.rsp0_valid_o, 0);
      end
      @(posedge clk); #1;

      // Test 5b: reset mid-RESP, then tie goes to req0
      bus.rsp0_ready_i = 0;
      send(0, 4'd2, 2, 2);
      @(negedge clk);
      @(negedge clk);
      chk("t5b_resp_valid", bus.rsp0_valid_o, 1);
      chk("t5b_resp_result", bus.rsp_result_o, 4);
      @(posedge clk); #3 rst = 1;
      #1;
      chk("t5b_rsp0_valid", bus.rsp0_valid_o, 0);
      chk("t5b_result", bus.rsp_result_o, 0);
      @(posedge clk); #1 rst = 0;
      repeat (3) begin
         @(negedge clk);
         chk("t5b_no_rsp", bus.rsp0_valid_o, 0);
      end
      @(posedge clk); #1;
      bus.rsp0_ready_i = 1;
      bus.req0_ctrl_i = 4'd0; bus.req0_src1_i = 32'hFF; bus.req0_src2_i = 32'h0F;
      bus.req1_ctrl_i = 4'd2; bus.req1_src1_i = 1; bus.req1_src2_i = 2;
      bus.req0_valid_i = 1; bus.req1_valid_i = 1;
      @(negedge clk);
      chk("t5b_tie_ready0", bus.req0_ready_o, 1);
      chk("t5b_tie_ready1", bus.req1_ready_o, 0);
      @(posedge clk); #1 bus.req0_valid_i = 0; bus.req1_valid_i = 0;
      @(negedge clk);
      @(negedge clk);
      chk("t5b_tie_result", bus.rsp_result_o, 32'h0F);
      @(posedge clk); #1;

      // Test 6: req1 OR
      bus.rsp1_ready_i = 1;
      send(1, 4'd1, 32'hF0F0_0000, 32'h0000_0F0F);
      @(negedge clk);
      chk("t6_exec_alu_ctrl", bus.alu_ctrl_o, 1);
      chk("t6_exec_valid", bus.rsp1_valid_o, 0);
      @(negedge clk);
      chk("t6_valid", bus.rsp1_valid_o, 1);
      chk("t6_result", bus.rsp_result_o, 32'hF0F0_0F0F);
      chk("t6_zero", bus.rsp_zero_o, 0);
      @(posedge clk); #1;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
